// File: rtl/sync_reset_pkg.sv
// Shared types and defaults for the sequence-sync reset generator.
// Holds the FSM state enum and a saturating counter helper.
package sync_reset_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        QUIET = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_HOLD_CYCLES  = 16;
    localparam int DEF_QUIET_CYCLES = 4;
    localparam int DEF_DRAIN_MAX    = 64;
    localparam int DEF_CNT_W        = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_reset_gen_reset_sync.sv
// Async-assert, sync-release synchronizer for the power-on reset.
// rst_sync_n follows reset_n low at once and rises STAGES edges later.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic rst_sync_n
);

    logic [STAGES-1:0] chain;

    // Shift ones in after release; clear the whole chain on assert
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chain <= '0;
        else          chain <= {chain[STAGES-2:0], 1'b1};
    end

    assign rst_sync_n = chain[STAGES-1];

endmodule

// File: rtl/sync_reset_gen.sv
// Sequence-sync reset generator: power-on and drained on-demand resets.
// Optional DRAIN timeout enabled by defining SYNC_RESET_GEN_TIMEOUT_EN.
module sync_reset_gen
    import sync_reset_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int QUIET_CYCLES = DEF_QUIET_CYCLES,
    parameter int DRAIN_MAX    = DEF_DRAIN_MAX,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_len,
    input  logic             idle,
    output logic             reset,
    output logic             run,
    output logic [7:0]       reset_count
`ifdef SYNC_RESET_GEN_TIMEOUT_EN
    ,
    output logic             drain_timeout
`endif
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] QUIET_L = CNT_W'(QUIET_CYCLES);
`ifdef SYNC_RESET_GEN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] DRAIN_L = CNT_W'(DRAIN_MAX);
`endif

    logic             rst_sync_n;
    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] len, len_n;
    logic [7:0]       count_n;
    logic             tmo_n;
    logic             reset_d, run_d, ready_d, tmo_d;

    reset_sync #(
        .STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .rst_sync_n(rst_sync_n)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state       <= HOLD;
            cnt         <= HOLD_L;
            len         <= HOLD_L;
            reset_count <= 8'd0;
            reset       <= 1'b1;
            run         <= 1'b0;
            req_ready   <= 1'b0;
`ifdef SYNC_RESET_GEN_TIMEOUT_EN
            drain_timeout <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            len         <= len_n;
            reset_count <= count_n;
            reset       <= reset_d;
            run         <= run_d;
            req_ready   <= ready_d;
`ifdef SYNC_RESET_GEN_TIMEOUT_EN
            drain_timeout <= tmo_d;
`endif
        end
    end

    // Next state, counter reload/decrement, length latch, request count
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        count_n = reset_count;
        tmo_n   = 1'b0;
        unique case (state)
            HOLD: begin
                if (cnt <= ONE) begin
                    state_n = QUIET;
                    cnt_n   = QUIET_L;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            QUIET: begin
                if (cnt <= ONE) state_n = RUN;
                else            cnt_n   = cnt - ONE;
            end
            RUN: begin
                if (req_valid && req_ready) begin
                    state_n = DRAIN;
                    len_n   = (req_len == '0) ? HOLD_L : req_len;
                    cnt_n   = ONE;
                end
            end
            DRAIN: begin
                if (idle) begin
                    state_n = HOLD;
                    cnt_n   = len;
                    count_n = sat_inc8(reset_count);
`ifdef SYNC_RESET_GEN_TIMEOUT_EN
                end else if (cnt >= DRAIN_L) begin
                    state_n = HOLD;
                    cnt_n   = len;
                    count_n = sat_inc8(reset_count);
                    tmo_n   = 1'b1;
                end else begin
                    cnt_n = cnt + ONE;
`endif
                end
            end
            default: begin
                state_n = HOLD;
                cnt_n   = HOLD_L;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        reset_d = (state_n == HOLD);
        run_d   = (state_n == RUN);
        ready_d = (state_n == RUN);
        tmo_d   = tmo_n;
    end

`ifndef SYNC_RESET_GEN_TIMEOUT_EN
    logic unused_tmo;
    assign unused_tmo = tmo_d;
`endif

endmodule
